uart_dbg_ctrl: RTL and testbench
================================

Name: uart_dbg_ctrl

Overview:
- UART debug command sequencer: parses host byte stream from UART RX core and drives single-outstanding OBI manager transactions (read/write bursts); returns replies via UART TX core.
- Also issues exec (boot address + fetch-enable pulse) and reports end-of-computation.
- Sits in croc_soc between UART byte core and main crossbar as alternative to JTAG SBA for loading and running binaries.

Parameters:
- TimeoutCycles, 1_000_000, idle cycles mid-command before abort; 0 disables timeout
- AddrWidth, 32, OBI address width
- DataWidth, 32, OBI data width; fixed 32 (4 bytes per word)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- rx_data_i  in  8  received byte
- rx_valid_i  in  1  rx byte valid
- rx_ready_o  out  1  controller accepts rx byte
- tx_data_o  out  8  byte to transmit
- tx_valid_o  out  1  tx byte valid
- tx_ready_i  in  1  tx core accepts byte
- obi_req_o  out  1  OBI request
- obi_gnt_i  in  1  OBI grant
- obi_addr_o  out  AddrWidth  word address, bits[1:0]=0
- obi_we_o  out  1  write enable
- obi_be_o  out  4  byte enable, always 4'hF
- obi_wdata_o  out  32  write data
- obi_rvalid_i  in  1  response valid
- obi_rdata_i  in  32  read data
- obi_err_i  in  1  response error, qualified by rvalid
- eoc_i  in  1  end-of-computation level (core status bit0)
- exec_o  out  1  one-cycle pulse: start core at boot_addr_o
- boot_addr_o  out  AddrWidth  latched exec address
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; eoc_pending 0; err flag 0; boot_addr_o 0.
- Byte codes: READ 0x11, WRITE 0x12, EXEC 0x13, ACK 0x06, EOT 0x04, EOC 0x14, NAK 0x15.
- Handshakes: rx byte consumed on rx_valid_i&rx_ready_o; tx byte transferred on tx_valid_o&tx_ready_i; tx_data_o stable while tx_valid_o&!tx_ready_i. OBI: req/addr/we/wdata held until gnt; exactly one outstanding; next req only after rvalid.
- States: IDLE, GET_ADDR (4 bytes little-endian), GET_LEN (1 byte N, 0 means 256 words), GET_WDATA (4 bytes LE), BUS_REQ, BUS_RSP, SEND_ACK, SEND_DATA (4 bytes LE), SEND_EOT, SEND_EOC.
- IDLE: if eoc_pending -> SEND_EOC (before accepting rx; rx_ready_o=0). Otherwise rx_ready_o=1; opcode 0x11/0x12/0x13 -> GET_ADDR; any other byte dropped, stay IDLE.
- eoc_pending set on rising edge of eoc_i (registered previous value) in any state; cleared when 0x14 transferred. Repeated edges while pending collapse to one.
- READ: GET_ADDR -> GET_LEN -> SEND_ACK -> per word: BUS_REQ(we=0) -> BUS_RSP -> SEND_DATA (4 bytes of rdata, LSB first) ; after Nth word -> SEND_EOT. Byte sent is 0x04 if no error in burst, else 0x15.
- WRITE: GET_ADDR -> GET_LEN -> per word: GET_WDATA -> BUS_REQ(we=1) -> BUS_RSP; after Nth -> SEND_ACK -> SEND_EOT (0x04/0x15 as above).
- EXEC: GET_ADDR -> boot_addr_o <= {addr[31:2],2'b00}, exec_o=1 for exactly one cycle -> SEND_ACK -> IDLE (no EOT).
- Address: low 2 bits of received address forced 0; +4 after each rvalid; wraps 0xFFFF_FFFC -> 0x0000_0000 silently.
- Word counter 9 bits; N=0 loads 256.
- obi_err_i on rvalid sets err flag (cleared in IDLE); read data still returned; burst continues.
- Timeout: counter reset on every rx byte; counts only in GET_ADDR/GET_LEN/GET_WDATA; reaching TimeoutCycles -> IDLE, no reply. Not counted during bus or tx states.
- rvalid without outstanding request ignored. Async reset mid-transaction aborts immediately; host must resend.

Decomposition:
- uart_dbg_pkg: byte-code localparams, state enum typedef, cmd_e enum.
- Sub-module uart_dbg_timeout (loadable down-counter with expire pulse); FSM/datapath in top.

Test Plan:
- Write/read-back: 12 00 00 00 10 02 + 78 56 34 12 EF BE AD DE -> OBI writes 0x1000_0000=0x1234_5678, 0x1000_0004=0xDEAD_BEEF; tx 06 04. Then 11 00 00 00 10 02 -> tx 06 78 56 34 12 EF BE AD DE 04.
- Bus error: read N=1 with obi_err_i=1 on rvalid, rdata 0xCAFE_F00D -> tx 06 0D F0 FE CA 15; next command replies 04.
- Exec: 13 81 00 00 10 -> boot_addr_o=0x1000_0080, exec_o single-cycle pulse, tx 06.
- EOC: eoc_i rises during READ N=4 with tx_ready_i toggling 1/0 -> burst completes with 04, then 14 sent once, before next opcode accepted.
- Timeout/garbage: bytes 55 AA ignored; 11 00 then stall TimeoutCycles=100 -> IDLE, no tx; next full command served normally.
- Wrap/N=0: read at 0xFFFF_FFFC, N=2 -> addrs 0xFFFF_FFFC, 0x0000_0000; N=0 -> exactly 256 OBI reads, 1026 tx bytes.

Source files
------------

// File: rtl/uart_dbg_pkg.sv
// Shared byte codes, FSM states and command kinds for the UART debug sequencer.
package uart_dbg_pkg;

  localparam logic [7:0] BYTE_READ  = 8'h11;
  localparam logic [7:0] BYTE_WRITE = 8'h12;
  localparam logic [7:0] BYTE_EXEC  = 8'h13;
  localparam logic [7:0] BYTE_ACK   = 8'h06;
  localparam logic [7:0] BYTE_EOT   = 8'h04;
  localparam logic [7:0] BYTE_EOC   = 8'h14;
  localparam logic [7:0] BYTE_NAK   = 8'h15;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_LEN,
    S_GET_WDATA,
    S_BUS_REQ,
    S_BUS_RSP,
    S_SEND_ACK,
    S_SEND_DATA,
    S_SEND_EOT,
    S_SEND_EOC
  } state_e;

  typedef enum logic [1:0] {
    CMD_READ,
    CMD_WRITE,
    CMD_EXEC
  } cmd_e;

endpackage

// File: rtl/uart_dbg_timeout.sv
// Inter-byte watchdog: reloads on every received byte or while disabled,
// counts down while enabled and flags the cycle the budget runs out.
module uart_dbg_timeout #(
  parameter int unsigned TimeoutCycles = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;

  logic [CntW-1:0] cnt;

  // Reload on activity/outside counting states, otherwise count down to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (clear || !enable) cnt <= CntW'(TimeoutCycles);
    else if (cnt != '0)       cnt <= cnt - CntW'(1);
  end

  // A zero budget means the watchdog never fires
  assign expire = (TimeoutCycles != 0) && enable && !clear && (cnt == CntW'(1));

endmodule

// File: rtl/uart_dbg_ctrl.sv
// UART debug command sequencer: host byte stream in, single-outstanding OBI
// bursts out, replies back over the UART TX byte interface.
module uart_dbg_ctrl
  import uart_dbg_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 1_000_000,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_valid_i,
  output logic                 rx_ready_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic                 obi_req_o,
  input  logic                 obi_gnt_i,
  output logic [AddrWidth-1:0] obi_addr_o,
  output logic                 obi_we_o,
  output logic [3:0]           obi_be_o,
  output logic [DataWidth-1:0] obi_wdata_o,
  input  logic                 obi_rvalid_i,
  input  logic [DataWidth-1:0] obi_rdata_i,
  input  logic                 obi_err_i,
  input  logic                 eoc_i,
  output logic                 exec_o,
  output logic [AddrWidth-1:0] boot_addr_o,
  output logic                 busy_o
);

  state_e               state, state_nxt;
  cmd_e                 cmd;
  logic [1:0]           byte_cnt;
  logic [8:0]           word_cnt;
  logic [23:0]          addr_sr;
  logic [31:0]          addr_full;
  logic [AddrWidth-1:0] addr;
  logic [DataWidth-1:0] wdata, rdata;
  logic                 err, eoc_q, eoc_pending, exec_q;
  logic [AddrWidth-1:0] boot_addr;
  logic                 rx_fire, tx_fire, last_byte, tmo_en, tmo;

  assign rx_fire   = rx_valid_i && rx_ready_o;
  assign tx_fire   = tx_valid_o && tx_ready_i;
  assign last_byte = (byte_cnt == 2'd3);
  assign tmo_en    = (state == S_GET_ADDR) || (state == S_GET_LEN) || (state == S_GET_WDATA);
  // Fourth address byte completes the little-endian word; low bits dropped
  assign addr_full = {rx_data_i, addr_sr} & ~32'h3;

  uart_dbg_timeout #(.TimeoutCycles(TimeoutCycles)) u_timeout (
    .clk    (clk_i),
    .rst    (rst_i),
    .clear  (rx_fire),
    .enable (tmo_en),
    .expire (tmo)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt  = state;
    rx_ready_o = 1'b0;
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    obi_req_o  = 1'b0;
    case (state)
      S_IDLE: begin
        // Pending end-of-computation is reported before any new opcode
        if (eoc_pending) state_nxt = S_SEND_EOC;
        else begin
          rx_ready_o = 1'b1;
          if (rx_fire && (rx_data_i == BYTE_READ || rx_data_i == BYTE_WRITE ||
                          rx_data_i == BYTE_EXEC))
            state_nxt = S_GET_ADDR;
        end
      end
      S_GET_ADDR: begin
        rx_ready_o = 1'b1;
        if (tmo) state_nxt = S_IDLE;
        else if (rx_fire && last_byte)
          state_nxt = (cmd == CMD_EXEC) ? S_SEND_ACK : S_GET_LEN;
      end
      S_GET_LEN: begin
        rx_ready_o = 1'b1;
        if (tmo) state_nxt = S_IDLE;
        else if (rx_fire) state_nxt = (cmd == CMD_READ) ? S_SEND_ACK : S_GET_WDATA;
      end
      S_GET_WDATA: begin
        rx_ready_o = 1'b1;
        if (tmo) state_nxt = S_IDLE;
        else if (rx_fire && last_byte) state_nxt = S_BUS_REQ;
      end
      S_BUS_REQ: begin
        obi_req_o = 1'b1;
        if (obi_gnt_i) state_nxt = S_BUS_RSP;
      end
      S_BUS_RSP: begin
        // word_cnt still counts the word being answered here
        if (obi_rvalid_i) begin
          if (cmd == CMD_READ)      state_nxt = S_SEND_DATA;
          else if (word_cnt == 9'd1) state_nxt = S_SEND_ACK;
          else                      state_nxt = S_GET_WDATA;
        end
      end
      S_SEND_ACK: begin
        tx_valid_o = 1'b1;
        tx_data_o  = BYTE_ACK;
        if (tx_fire) begin
          case (cmd)
            CMD_READ:  state_nxt = S_BUS_REQ;
            CMD_WRITE: state_nxt = S_SEND_EOT;
            default:   state_nxt = S_IDLE;
          endcase
        end
      end
      S_SEND_DATA: begin
        tx_valid_o = 1'b1;
        tx_data_o  = rdata[{byte_cnt, 3'b000} +: 8];
        if (tx_fire && last_byte) state_nxt = (word_cnt == 9'd0) ? S_SEND_EOT : S_BUS_REQ;
      end
      S_SEND_EOT: begin
        tx_valid_o = 1'b1;
        tx_data_o  = err ? BYTE_NAK : BYTE_EOT;
        if (tx_fire) state_nxt = S_IDLE;
      end
      S_SEND_EOC: begin
        tx_valid_o = 1'b1;
        tx_data_o  = BYTE_EOC;
        if (tx_fire) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command datapath: byte assembly, burst address/count, error and EOC flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmd         <= CMD_READ;
      byte_cnt    <= 2'd0;
      word_cnt    <= 9'd0;
      addr_sr     <= '0;
      addr        <= '0;
      wdata       <= '0;
      rdata       <= '0;
      err         <= 1'b0;
      eoc_q       <= 1'b0;
      eoc_pending <= 1'b0;
      exec_q      <= 1'b0;
      boot_addr   <= '0;
    end else begin
      exec_q <= 1'b0;
      eoc_q  <= eoc_i;
      if (eoc_i && !eoc_q)                     eoc_pending <= 1'b1;
      else if (state == S_SEND_EOC && tx_fire) eoc_pending <= 1'b0;
      case (state)
        S_IDLE: begin
          err      <= 1'b0;
          byte_cnt <= 2'd0;
          if (rx_fire) begin
            case (rx_data_i)
              BYTE_READ:  cmd <= CMD_READ;
              BYTE_WRITE: cmd <= CMD_WRITE;
              BYTE_EXEC:  cmd <= CMD_EXEC;
              default:    ;
            endcase
          end
        end
        S_GET_ADDR: if (rx_fire) begin
          addr_sr  <= {rx_data_i, addr_sr[23:8]};
          byte_cnt <= byte_cnt + 2'd1;
          if (last_byte) begin
            addr <= AddrWidth'(addr_full);
            if (cmd == CMD_EXEC) begin
              boot_addr <= AddrWidth'(addr_full);
              exec_q    <= 1'b1;
            end
          end
        end
        S_GET_LEN: if (rx_fire) begin
          word_cnt <= (rx_data_i == 8'h00) ? 9'd256 : {1'b0, rx_data_i};
          byte_cnt <= 2'd0;
        end
        S_GET_WDATA: if (rx_fire) begin
          wdata    <= {rx_data_i, wdata[DataWidth-1:8]};
          byte_cnt <= byte_cnt + 2'd1;
        end
        S_BUS_RSP: if (obi_rvalid_i) begin
          rdata    <= obi_rdata_i;
          err      <= err | obi_err_i;
          addr     <= addr + AddrWidth'(4);
          word_cnt <= word_cnt - 9'd1;
          byte_cnt <= 2'd0;
        end
        S_SEND_DATA: if (tx_fire) byte_cnt <= byte_cnt + 2'd1;
        default: ;
      endcase
    end
  end

  assign obi_addr_o  = addr;
  assign obi_we_o    = obi_req_o && (cmd == CMD_WRITE);
  assign obi_be_o    = obi_req_o ? 4'hF : 4'h0;
  assign obi_wdata_o = wdata;
  assign exec_o      = exec_q;
  assign boot_addr_o = boot_addr;
  assign busy_o      = (state != S_IDLE);

endmodule

// File: tb/tb_uart_dbg_ctrl.sv
// Randomized self-checking bench: host byte stream, OBI memory responder,
// and a queue-based reference model of the replies and bus transactions.
module tb_uart_dbg_ctrl;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } obi_t;

  logic        clk, rst;
  logic [7:0]  rx_data, tx_data;
  logic        rx_valid, rx_ready, tx_valid, tx_ready;
  logic        obi_req, obi_gnt, obi_we, obi_rvalid, obi_err;
  logic [31:0] obi_addr, obi_wdata, obi_rdata, boot_addr;
  logic [3:0]  obi_be;
  logic        eoc, exec, busy;

  int checks = 0, failures = 0;
  int tx_cnt = 0, gnt_cnt = 0, exec_cnt = 0, exp_exec_cnt = 0;
  int tx_mode = 0;
  bit stray_en = 0;
  logic [31:0] err_addr = 32'h1;
  logic [31:0] exp_boot = 32'h0;

  logic [7:0]  exp_tx[$];
  obi_t        exp_obi[$];
  logic [7:0]  hostq[$];
  logic [7:0]  lit[$];
  logic [31:0] wq[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] slave_mem[logic [31:0]];

  uart_dbg_ctrl #(.TimeoutCycles(100), .AddrWidth(32), .DataWidth(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .obi_req_o(obi_req), .obi_gnt_i(obi_gnt), .obi_addr_o(obi_addr), .obi_we_o(obi_we),
    .obi_be_o(obi_be), .obi_wdata_o(obi_wdata), .obi_rvalid_i(obi_rvalid),
    .obi_rdata_i(obi_rdata), .obi_err_i(obi_err),
    .eoc_i(eoc), .exec_o(exec), .boot_addr_o(boot_addr), .busy_o(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  function automatic bit is_err(input logic [31:0] a);
    return a == err_addr;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic push4(input logic [31:0] v);
    for (int k = 0; k < 4; k++) hostq.push_back(v[8*k +: 8]);
  endtask

  task automatic do_read(input logic [31:0] a0, input int n);
    int words;
    bit e;
    logic [31:0] a, d;
    obi_t t;
    words = (n == 0) ? 256 : n;
    e = 0;
    a = a0 & ~32'h3;
    hostq.push_back(8'h11); push4(a0); hostq.push_back(8'(n));
    exp_tx.push_back(8'h06);
    for (int i = 0; i < words; i++) begin
      t.addr = a; t.we = 1'b0; t.wdata = 32'h0;
      exp_obi.push_back(t);
      d = ref_rd(a);
      e = e | is_err(a);
      for (int k = 0; k < 4; k++) exp_tx.push_back(d[8*k +: 8]);
      a = a + 32'd4;
    end
    exp_tx.push_back(e ? 8'h15 : 8'h04);
  endtask

  task automatic do_write(input logic [31:0] a0, input int n);
    int words;
    bit e;
    logic [31:0] a;
    obi_t t;
    words = (n == 0) ? 256 : n;
    e = 0;
    a = a0 & ~32'h3;
    hostq.push_back(8'h12); push4(a0); hostq.push_back(8'(n));
    for (int i = 0; i < words; i++) begin
      push4(wq[i]);
      t.addr = a; t.we = 1'b1; t.wdata = wq[i];
      exp_obi.push_back(t);
      ref_mem[a] = wq[i];
      e = e | is_err(a);
      a = a + 32'd4;
    end
    exp_tx.push_back(8'h06);
    exp_tx.push_back(e ? 8'h15 : 8'h04);
  endtask

  task automatic do_exec(input logic [31:0] a0);
    hostq.push_back(8'h13); push4(a0);
    exp_boot = a0 & ~32'h3;
    exp_exec_cnt++;
    exp_tx.push_back(8'h06);
  endtask

  task automatic pin_tx(input string nm);
    bit bad;
    bad = (exp_tx.size() != lit.size());
    if (!bad) foreach (lit[i]) if (exp_tx[i] !== lit[i]) bad = 1;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL %s: model reply has %0d bytes, expected %0d literal bytes", nm, exp_tx.size(), lit.size());
    end
  endtask

  // ---------------- host side ----------------
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = b;
    forever begin
      @(negedge clk);
      if (rx_ready) break;
      n++;
      if (n > 20000) begin
        checks++; failures++;
        $display("FAIL rx_accept: byte %02h not accepted, required acceptance within 20000 cycles", b);
        break;
      end
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic send_host();
    while (hostq.size() > 0) send_byte(hostq.pop_front());
  endtask

  task automatic wait_done(input string nm);
    int n;
    bit ok;
    n = 0; ok = 0;
    while (n < 30000) begin
      @(negedge clk);
      if (exp_tx.size() == 0 && exp_obi.size() == 0 && !busy) begin ok = 1; break; end
      n++;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_done: pending tx=%0d obi=%0d busy=%0b, required all drained",
               nm, exp_tx.size(), exp_obi.size(), busy);
      exp_tx.delete(); exp_obi.delete();
    end
  endtask

  // ---------------- tx sink ----------------
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (tx_mode)
        0:       tx_ready = ($urandom % 4) != 0;
        1:       tx_ready = !tx_ready;
        default: tx_ready = 1'b1;
      endcase
    end
  end

  // ---------------- OBI memory responder ----------------
  initial begin
    bit pend;
    int dly;
    logic [31:0] pdata;
    bit perr;
    pend = 0; dly = 0; pdata = 0; perr = 0;
    obi_gnt = 0; obi_rvalid = 0; obi_err = 0; obi_rdata = 0;
    forever begin
      @(posedge clk); #1;
      obi_gnt = 0; obi_rvalid = 0; obi_err = 0;
      if (pend) begin
        if (dly == 0) begin
          obi_rvalid = 1; obi_rdata = pdata; obi_err = perr; pend = 0;
        end else dly--;
      end else if (obi_req && ($urandom % 3) != 0) begin
        obi_gnt = 1;
        if (obi_we) slave_mem[obi_addr] = obi_wdata;
        pdata = slave_mem.exists(obi_addr) ? slave_mem[obi_addr] : dflt(obi_addr);
        perr = is_err(obi_addr);
        pend = 1;
        dly = $urandom_range(0, 2);
      end else if (stray_en && !busy && ($urandom % 4) == 0) begin
        obi_rvalid = 1; obi_rdata = $urandom; obi_err = 1;
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    obi_t e;
    bit prev_tx_stall, prev_req_wait, prev_exec;
    logic [7:0] prev_tx_data;
    logic [31:0] prev_addr;
    logic prev_we;
    prev_tx_stall = 0; prev_req_wait = 0; prev_exec = 0;
    prev_tx_data = 0; prev_addr = 0; prev_we = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_req_wait) check("obi_hold", {obi_req, obi_addr, obi_we}, {1'b1, prev_addr, prev_we});
        if (obi_req) check("obi_be", obi_be, 4'hF);
        if (obi_req && obi_gnt) begin
          gnt_cnt++;
          if (exp_obi.size() == 0) begin
            checks++; failures++;
            $display("FAIL obi_unexpected: got addr %0h we %0b, expected no request", obi_addr, obi_we);
          end else begin
            e = exp_obi.pop_front();
            check("obi_addr", obi_addr, e.addr);
            check("obi_we", obi_we, e.we);
            if (e.we) check("obi_wdata", obi_wdata, e.wdata);
          end
        end
        prev_req_wait = obi_req && !obi_gnt;
        prev_addr = obi_addr; prev_we = obi_we;

        if (prev_tx_stall) check("tx_hold", {tx_valid, tx_data}, {1'b1, prev_tx_data});
        if (tx_valid && tx_ready) begin
          tx_cnt++;
          if (exp_tx.size() == 0) begin
            checks++; failures++;
            $display("FAIL tx_unexpected: got %02h, expected no byte", tx_data);
          end else check("tx_byte", tx_data, exp_tx.pop_front());
        end
        prev_tx_stall = tx_valid && !tx_ready;
        prev_tx_data = tx_data;

        if (exec) begin
          exec_cnt++;
          check("exec_width", prev_exec, 1'b0);
          check("exec_boot", boot_addr, exp_boot);
        end
        prev_exec = exec;
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int before_tx, before_gnt, r, n;
    logic [31:0] a;
    logic [7:0] g;
    rst = 1; rx_valid = 0; rx_data = 0; eoc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {tx_valid, tx_data, obi_req, obi_addr, obi_we, obi_be, exec, busy}, 64'h0);
    check("rst_boot_wdata", {boot_addr, obi_wdata}, 64'h0);
    @(posedge clk); #1;
    rst = 0;

    // write then read back
    wq = '{32'h1234_5678, 32'hDEAD_BEEF};
    do_write(32'h1000_0000, 2);
    lit = '{8'h06, 8'h04};
    pin_tx("pin_write_reply");
    send_host(); wait_done("write");
    check("mem_word0", slave_mem[32'h1000_0000], 32'h1234_5678);
    check("mem_word1", slave_mem[32'h1000_0004], 32'hDEAD_BEEF);
    do_read(32'h1000_0000, 2);
    lit = '{8'h06, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04};
    pin_tx("pin_read_reply");
    send_host(); wait_done("readback");

    // bus error: data still returned, NAK at the end, flag clears afterwards
    err_addr = 32'h2000_0000;
    slave_mem[32'h2000_0000] = 32'hCAFE_F00D;
    ref_mem[32'h2000_0000]   = 32'hCAFE_F00D;
    do_read(32'h2000_0000, 1);
    lit = '{8'h06, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'h15};
    pin_tx("pin_err_reply");
    send_host(); wait_done("buserr");
    err_addr = 32'h1;
    do_read(32'h1000_0004, 1);
    lit = '{8'h06, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04};
    pin_tx("pin_after_err");
    send_host(); wait_done("after_err");

    // exec
    do_exec(32'h1000_0081);
    send_host(); wait_done("exec");
    check("boot_addr", boot_addr, 32'h1000_0080);
    check("exec_pulses", exec_cnt, 1);

    // eoc edges during a throttled burst collapse into one 0x14 after it
    tx_mode = 1;
    do_read(32'h1000_0000, 4);
    send_host();
    exp_tx.push_back(8'h14);
    eoc = 1; repeat (4) @(posedge clk); #1;
    eoc = 0; repeat (3) @(posedge clk); #1;
    eoc = 1; repeat (4) @(posedge clk); #1;
    eoc = 0;
    do_read(32'h1000_0004, 1);
    send_host(); wait_done("eoc");
    tx_mode = 0;

    // garbage bytes, then a stalled command that must time out silently
    stray_en = 1;
    hostq = '{8'h55, 8'hAA, 8'h11, 8'h00};
    send_host();
    repeat (50) @(negedge clk);
    check("tmo_still_busy", busy, 1'b1);
    repeat (60) @(negedge clk);
    check("tmo_back_idle", busy, 1'b0);
    do_read(32'h1000_0000, 2);
    send_host(); wait_done("after_tmo");

    // address wrap
    do_read(32'hFFFF_FFFC, 2);
    check("pin_wrap_a0", exp_obi[0].addr, 32'hFFFF_FFFC);
    check("pin_wrap_a1", exp_obi[1].addr, 32'h0000_0000);
    send_host(); wait_done("wrap");

    // N=0 means 256 words
    before_tx = tx_cnt; before_gnt = gnt_cnt;
    do_read(32'h3000_0000, 0);
    send_host(); wait_done("n256");
    check("n256_tx_bytes", tx_cnt - before_tx, 1026);
    check("n256_obi_reads", gnt_cnt - before_gnt, 256);

    // random command mix
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 4);
      n = $urandom_range(1, 6);
      a = (r == 4) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      err_addr = (($urandom % 4) == 0) ? ((a & ~32'h3) + 32'(4 * $urandom_range(0, n - 1))) : 32'h1;
      case (r)
        0, 4: do_read(a, n);
        1: begin
          wq = {};
          for (int i = 0; i < n; i++) wq.push_back($urandom);
          do_write(a, n);
        end
        2: do_exec(a);
        default: begin
          g = 8'($urandom);
          if (g == 8'h11 || g == 8'h12 || g == 8'h13) g = 8'hA5;
          hostq.push_back(g);
        end
      endcase
      send_host(); wait_done("random");
    end
    err_addr = 32'h1;

    check("exec_count", exec_cnt, exp_exec_cnt);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
